hash_streamer: RTL and testbench

HASH_STREAMER -- requirements
Module: hash_streamer

---
 rtl/spongent_pkg.sv | 9 +
 rtl/counter.sv | 18 +
 rtl/hash_streamer.sv | 76 +++++++
 tb/tb_hash_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spongent_pkg.sv
// spongent_pkg: shared types and helpers for the spongent hash datapath.
//   state_t : streamer FSM states (IDLE, SEND)
//   words() : number of OUT_WIDTH-bit words in an N-bit digest
package spongent_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  function automatic int words(input int n, input int w);
    return n / w;
  endfunction
endpackage

// File: rtl/counter.sv
// counter: W-bit up/down counter with synchronous active-high reset.
//   clk, rst : clock, sync reset to 0
//   up, down : increment / decrement requests (both high cancels)
//   count    : current value
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count + W'(up) - W'(down);
  end
endmodule

// File: rtl/hash_streamer.sv
// hash_streamer: serialises a finished sponge digest into MSB-first words.
//   clk, rst          : clock, sync active-high reset
//   end_hash, hash    : sponge done level and digest (valid while end_hash=1)
//   out_data/valid/ready/last : valid-ready word stream, last marks final word
//   busy              : digest held and not fully sent
//   overrun           : sticky, a new digest arrived while busy
module hash_streamer import spongent_pkg::*; #(
  parameter int N         = 256,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 end_hash,
  input  logic [N-1:0]         hash,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);
  localparam int WORDS = words(N, OUT_WIDTH);
  localparam int CW    = $clog2(WORDS) + 1;

  if (N % OUT_WIDTH != 0 || N < OUT_WIDTH) begin : g_bad_width
    $error("hash_streamer: N must be a non-zero multiple of OUT_WIDTH");
  end

  state_t         r_state, w_next;
  logic           r_end_q, r_overrun;
  logic [N-1:0]   r_sreg;
  logic [CW-1:0]  w_cnt;
  logic           w_start, w_xfer, w_last, w_final, w_cnt_rst;

  assign out_valid = (r_state == SEND);
  assign out_data  = out_valid ? r_sreg[N-1 -: OUT_WIDTH] : '0;
  assign out_last  = w_last;
  assign busy      = (r_state == SEND);
  assign overrun   = r_overrun;

  always_comb begin
    w_start   = end_hash & ~r_end_q;
    w_xfer    = out_valid & out_ready;
    w_last    = (r_state == SEND) && (w_cnt == CW'(WORDS - 1));
    w_final   = w_xfer & w_last;
    // a start landing on the final transfer chains straight into the next digest
    w_next    = (r_state == IDLE) ? (w_start ? SEND : IDLE) : (w_final & ~w_start ? IDLE : SEND);
    w_cnt_rst = rst | w_final | (w_start & (r_state == IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_end_q   <= 1'b0;
      r_sreg    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_end_q <= end_hash;
      if (w_start & ((r_state == IDLE) | w_final)) r_sreg <= hash;
      else if (w_xfer)                              r_sreg <= r_sreg << OUT_WIDTH;
      if (w_start & (r_state == SEND) & ~w_final)   r_overrun <= 1'b1;
    end
  end

  counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst   (w_cnt_rst),
    .up    (w_xfer),
    .down  (1'b0),
    .count (w_cnt)
  );
endmodule

// File: tb/tb_hash_streamer.sv
// tb_hash_streamer: directed self-checking bench for hash_streamer (N=256, OUT_WIDTH=8).
module tb_hash_streamer;
  localparam logic [255:0] H1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] H2 = ~H1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         end_hash = 1'b0;
  logic [255:0] hash = '0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;
  logic         overrun;
  int           checks = 0;
  int           failures = 0;

  hash_streamer #(.N(256), .OUT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .end_hash  (end_hash),
    .hash      (hash),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; end_hash = 1'b0; out_ready = 1'b1; hash = H1;
    step; step;
    checks++;
    if ({out_valid, out_last, busy, overrun} !== 4'b0 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b overrun=%b data=%h, expected all 0",
               out_valid, out_last, busy, overrun, out_data);
    end
    rst = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_basic;
    hash = H1; end_hash = 1'b1; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: valid=%b before start edge, expected 0", out_valid);
    end
    step;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || out_last !== (i == 31) || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_word%0d: valid=%b data=%h last=%b busy=%b, expected 1 %h %b 1",
                 i, out_valid, out_data, out_last, busy, 8'(i), (i == 31));
      end
      step;
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL basic_done: busy=%b valid=%b data=%h, expected 0 0 00", busy, out_valid, out_data);
    end
    end_hash = 1'b0;
    step;
  endtask

  task automatic test_stall;
    int idx = 0;
    hash = H1; end_hash = 1'b1; out_ready = 1'b0;
    step;
    end_hash = 1'b0;
    for (int c = 0; c < 200 && idx < 32; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(idx) || out_last !== (idx == 31)) begin
        failures++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 c, out_valid, out_data, out_last, 8'(idx), (idx == 31));
      end
      if (out_ready) idx++;
      step;
    end
    out_ready = 1'b1;
    checks++;
    if (idx !== 32 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_done: words=%0d busy=%b, expected 32 0", idx, busy);
    end
    step;
  endtask

  task automatic test_held;
    int n_xfer = 0;
    int n_last = 0;
    hash = H1; end_hash = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_ready) n_xfer++;
      if (out_last) n_last++;
      step;
    end
    checks++;
    if (n_xfer !== 32 || n_last !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL held_one_burst: transfers=%0d lasts=%0d busy=%b, expected 32 1 0", n_xfer, n_last, busy);
    end
    end_hash = 1'b0;
    step;
  endtask

  task automatic test_overrun;
    int n_valid = 0;
    hash = H1; end_hash = 1'b1; out_ready = 1'b1;
    step;
    end_hash = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        hash = H2; end_hash = 1'b1;
        checks++;
        if (overrun !== 1'b0) begin
          failures++;
          $display("FAIL overrun_early: overrun=%b, expected 0", overrun);
        end
      end
      if (i == 12) begin
        checks++;
        if (overrun !== 1'b1) begin
          failures++;
          $display("FAIL overrun_set: overrun=%b, expected 1", overrun);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || out_last !== (i == 31)) begin
        failures++;
        $display("FAIL overrun_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 i, out_valid, out_data, out_last, 8'(i), (i == 31));
      end
      step;
    end
    for (int c = 0; c < 40; c++) begin
      if (out_valid) n_valid++;
      step;
    end
    checks++;
    if (n_valid !== 0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_no_second: valid_cycles=%0d overrun=%b, expected 0 1", n_valid, overrun);
    end
    end_hash = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    rst = 1'b1; end_hash = 1'b0;
    step;
    rst = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_cleared_by_rst: overrun=%b, expected 0", overrun);
    end
    hash = H1; end_hash = 1'b1; out_ready = 1'b1;
    step;
    end_hash = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        hash = H2; end_hash = 1'b1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || out_last !== (i == 31)) begin
        failures++;
        $display("FAIL b2b_first_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 i, out_valid, out_data, out_last, 8'(i), (i == 31));
      end
      step;
    end
    end_hash = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(255 - i) || out_last !== (i == 31) || overrun !== 1'b0) begin
        failures++;
        $display("FAIL b2b_second_word%0d: valid=%b data=%h last=%b overrun=%b, expected 1 %h %b 0",
                 i, out_valid, out_data, out_last, overrun, 8'(255 - i), (i == 31));
      end
      step;
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: busy=%b overrun=%b, expected 0 0", busy, overrun);
    end
    step;
  endtask

  task automatic test_reset_mid;
    hash = H1; end_hash = 1'b1; out_ready = 1'b1;
    step;
    for (int i = 0; i < 5; i++) step;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h05) begin
      failures++;
      $display("FAIL rstmid_word5: valid=%b data=%h, expected 1 05", out_valid, out_data);
    end
    rst = 1'b1;
    step;
    checks++;
    if ({out_valid, out_last, busy, overrun} !== 4'b0 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs: valid=%b last=%b busy=%b overrun=%b data=%h, expected all 0",
               out_valid, out_last, busy, overrun, out_data);
    end
    rst = 1'b0;
    step;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || out_last !== (i == 31)) begin
        failures++;
        $display("FAIL rstmid_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 i, out_valid, out_data, out_last, 8'(i), (i == 31));
      end
      step;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_done: busy=%b, expected 0", busy);
    end
    end_hash = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_held;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
